// File: rtl/pdm_pkg.sv
// Constants and state encoding shared by the PCM packer and the PDM serializer.
// Changing C_NR_OF_BITS here retargets both ends of the word interface.
package pdm_pkg;
    localparam int C_NR_OF_BITS = 32;
    localparam logic [C_NR_OF_BITS-1:0] C_MIDSCALE = 32'h5555_5555;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BUILD = 2'd2,
        FULL  = 2'd3
    } pdm_state_t;
endpackage

// File: rtl/pdm_dsm1.sv
// First-order delta-sigma modulator: one PDM bit per step, combinational bit_o.
// Latency: bit_o reflects the current accumulator; accumulator advances on step_i.
module pdm_dsm1 #(
    parameter int C_PCM_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clr_i,
    input  logic                   step_i,
    input  logic [C_PCM_WIDTH-1:0] sample_i,
    output logic                   bit_o
);
    logic [C_PCM_WIDTH-1:0] acc;
    logic [C_PCM_WIDTH-1:0] u;
    logic [C_PCM_WIDTH:0]   sum;

    // Offset binary: flipping the sign bit maps -full..+full onto 0..2^W-1.
    assign u     = {~sample_i[C_PCM_WIDTH-1], sample_i[C_PCM_WIDTH-2:0]};
    assign sum   = {1'b0, acc} + {1'b0, u};
    assign bit_o = sum[C_PCM_WIDTH];

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            acc <= '0;
        end else if (step_i) begin
            acc <= sum[C_PCM_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/pcm_pdm_packer.sv
// Accepts PCM samples, modulates to PDM, packs MSB-first words for the serializer.
// Each word_done_i hands over the finished word, or midscale plus an underrun pulse.
module pcm_pdm_packer
    import pdm_pkg::*;
#(
    parameter int C_PCM_WIDTH        = 16,
    parameter int C_WORDS_PER_SAMPLE = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic [C_PCM_WIDTH-1:0]  sample_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    input  logic                    word_done_i,
    output logic [C_NR_OF_BITS-1:0] data_o,
    output logic                    underrun_o
);
    localparam int BCW = $clog2(C_NR_OF_BITS);
    localparam int WCW = (C_WORDS_PER_SAMPLE > 1) ? $clog2(C_WORDS_PER_SAMPLE) : 1;

    pdm_state_t              state;
    logic [C_PCM_WIDTH-1:0]  sample_q;
    logic [C_NR_OF_BITS-1:0] build_q;
    logic [BCW-1:0]          bit_cnt;
    logic [WCW-1:0]          word_cnt;
    logic                    pdm_bit;

    pdm_dsm1 #(
        .C_PCM_WIDTH(C_PCM_WIDTH)
    ) u_dsm (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (!en_i),
        .step_i   (en_i && (state == BUILD)),
        .sample_i (sample_q),
        .bit_o    (pdm_bit)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            data_o         <= C_MIDSCALE;
            sample_ready_o <= 1'b0;
            underrun_o     <= 1'b0;
            sample_q       <= '0;
            build_q        <= '0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
        end else if (!en_i) begin
            state          <= IDLE;
            data_o         <= C_MIDSCALE;
            sample_ready_o <= 1'b0;
            underrun_o     <= 1'b0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
        end else begin
            underrun_o <= 1'b0;
            // Any done pulse outside FULL finds no word ready.
            if (word_done_i && (state != FULL)) begin
                data_o     <= C_MIDSCALE;
                underrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    state          <= FETCH;
                    sample_ready_o <= 1'b1;
                end
                FETCH: begin
                    if (sample_valid_i) begin
                        sample_q       <= sample_i;
                        bit_cnt        <= '0;
                        state          <= BUILD;
                        sample_ready_o <= 1'b0;
                    end
                end
                BUILD: begin
                    // Shifting in from the LSB leaves the first bit in the MSB after a full word.
                    build_q <= {build_q[C_NR_OF_BITS-2:0], pdm_bit};
                    if (bit_cnt == BCW'(C_NR_OF_BITS - 1)) begin
                        state <= FULL;
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                FULL: begin
                    if (word_done_i) begin
                        data_o <= build_q;
                        if (word_cnt == WCW'(C_WORDS_PER_SAMPLE - 1)) begin
                            word_cnt       <= '0;
                            state          <= FETCH;
                            sample_ready_o <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                            bit_cnt  <= '0;
                            state    <= BUILD;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    sample_ready_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcm_pdm_packer.sv
// Directed and randomized bench for pcm_pdm_packer against an arithmetic delta-sigma model.
module tb_pcm_pdm_packer;
    localparam logic [31:0] MID = 32'h5555_5555;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        word_done = 1'b0;
    logic [31:0] data;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int m_acc = 0;   // model accumulator, 0..65535
    int m_u = 0;     // model input as offset value 0..65535
    logic [31:0] exp_w;

    always #5 clk = ~clk;

    pcm_pdm_packer dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .en_i           (en),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready),
        .word_done_i    (word_done),
        .data_o         (data),
        .underrun_o     (underrun)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Density model: the accumulator overflows in proportion to (sample + 32768) / 65536.
    task automatic model_word(output logic [31:0] w);
        w = '0;
        for (int b = 0; b < 32; b++) begin
            m_acc = m_acc + m_u;
            if (m_acc >= 65536) begin
                m_acc = m_acc - 65536;
                w = {w[30:0], 1'b1};
            end else begin
                w = {w[30:0], 1'b0};
            end
        end
    endtask

    task automatic send_sample(input logic [15:0] s);
        int n;
        n = 0;
        while (sample_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, sample_ready}, 32'd1);
        sample = s;
        sample_valid = 1'b1;
        m_u = int'($signed(s)) + 32768;
        tick();
        sample_valid = 1'b0;
        sample = $urandom();
        chk("ready_low_in_build", {31'd0, sample_ready}, 32'd0);
    endtask

    // Called right after a word starts building; waits for FULL, transfers, checks.
    task automatic build_and_xfer(input string tag, input int extra);
        logic [31:0] w;
        tick(32 + extra);
        model_word(w);
        exp_w = w;
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk(tag, data, w);
        chk({tag, "_no_underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    task automatic pulse_underrun(input string tag);
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk({tag, "_underrun"}, {31'd0, underrun}, 32'd1);
        chk({tag, "_mid"}, data, MID);
        tick();
        chk({tag, "_underrun_1cyc"}, {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        logic [15:0] s;
        logic [31:0] w;

        // Reset with enable low
        tick(3);
        rstn = 1'b1;
        chk("rst_data", data, MID);
        chk("rst_ready", {31'd0, sample_ready}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk("dis_no_underrun", {31'd0, underrun}, 32'd0);
        chk("dis_data", data, MID);

        // Enable; zero sample gives midscale words
        en = 1'b1;
        tick();
        chk("fetch_ready", {31'd0, sample_ready}, 32'd1);
        m_acc = 0;
        send_sample(16'h0000);
        build_and_xfer("zero_w0", 0);
        chk("zero_w0_const", data, MID);
        build_and_xfer("zero_w1", 2);
        chk("zero_w1_const", data, MID);
        chk("ready_after_pair", {31'd0, sample_ready}, 32'd1);

        // Full-scale positive and negative
        send_sample(16'h7FFF);
        build_and_xfer("pos_w0", 0);
        chk("pos_w0_const", data, 32'h7FFF_FFFF);
        build_and_xfer("pos_w1", 1);
        send_sample(16'h8000);
        build_and_xfer("neg_w0", 0);
        chk("neg_w0_const", data, 32'h0000_0000);
        build_and_xfer("neg_w1", 0);
        chk("neg_w1_const", data, 32'h0000_0000);

        // Underrun while waiting for a sample
        tick(2);
        pulse_underrun("fetch");
        chk("fetch_ready_kept", {31'd0, sample_ready}, 32'd1);
        send_sample(16'h1234);
        build_and_xfer("after_ur_w0", 0);
        build_and_xfer("after_ur_w1", 0);

        // Done pulse on the last BUILD cycle, then the completed word transfers
        send_sample(16'hC000);
        tick(31);
        pulse_underrun("lastbuild");
        model_word(w);
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk("lastbuild_xfer", data, w);
        build_and_xfer("lastbuild_w1", 0);

        // Randomized samples and handshake delays
        for (int k = 0; k < 8; k++) begin
            s = 16'($urandom());
            tick($urandom_range(0, 3));
            send_sample(s);
            build_and_xfer("rand_w0", int'($urandom_range(0, 4)));
            build_and_xfer("rand_w1", int'($urandom_range(0, 4)));
        end

        // Drop enable mid-build; accumulator must restart from zero
        send_sample(16'h3A5C);
        tick(10);
        en = 1'b0;
        tick();
        chk("drop_ready", {31'd0, sample_ready}, 32'd0);
        chk("drop_data", data, MID);
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk("drop_no_underrun", {31'd0, underrun}, 32'd0);
        m_acc = 0;
        en = 1'b1;
        tick();
        send_sample(16'h0000);
        build_and_xfer("reen_w0", 0);
        chk("reen_w0_const", data, MID);
        build_and_xfer("reen_w1", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
